// File: rtl/riscv_mmu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mmu_pkg
// Shared definitions for the Sv39/Sv48 page-table walker:
//   - walk_state_e : walker FSM states
//   - PTE_*        : bit positions inside a 64-bit page-table entry
//   - SYSBUS_*     : system bus tag for a memory read request
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } walk_state_e;

    // PTE field positions
    localparam int PTE_V   = 0;
    localparam int PTE_R   = 1;
    localparam int PTE_W   = 2;
    localparam int PTE_X   = 3;
    localparam int PPN_LSB = 10;
    localparam int PPN_MSB = 53;
    localparam int PPN_W   = PPN_MSB - PPN_LSB + 1;

    // System bus request tag: read command in bit 12, memory target in 11:8
    localparam logic [0:0]  SYSBUS_READ       = 1'b1;
    localparam logic [3:0]  SYSBUS_MEMORY     = 4'h1;
    localparam logic [12:0] SYSBUS_RD_MEM_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

endpackage

// File: rtl/sv_page_walker_pte_check.sv
// ---------------------------------------------------------------------------
// pte_check
// Combinational evaluation of one fetched PTE at the current walk level.
// Ports:
//   pte       in  64     entry captured from the bus line
//   lvl       in  LVL_W  level the entry was fetched at
//   vaddr     in  64     virtual address being translated
//   leaf      out 1      entry is a leaf (R or X set)
//   fault     out 1      walk must stop with a page fault
//   next_base out 64     next-level table base (PPN << PAGE_SHIFT)
//   paddr     out 64     translated address, valid when leaf && !fault
// ---------------------------------------------------------------------------
module pte_check
    import riscv_mmu_pkg::*;
#(
    parameter int LEVELS     = 4,
    parameter int VPN_WIDTH  = 9,
    parameter int PAGE_SHIFT = 12,
    parameter int LVL_W      = 2
) (
    input  logic [63:0]      pte,
    input  logic [LVL_W-1:0] lvl,
    input  logic [63:0]      vaddr,
    output logic             leaf,
    output logic             fault,
    output logic [63:0]      next_base,
    output logic [63:0]      paddr
);

    logic [PPN_W-1:0] ppn;
    logic [63:0]      ppn_addr;
    logic [63:0]      sp_mask;
    logic             v_bit;
    logic             r_bit;
    logic             w_bit;
    logic             x_bit;
    logic             unused_bits;

    assign ppn      = pte[PPN_MSB:PPN_LSB];
    assign ppn_addr = {{(64 - PPN_W - PAGE_SHIFT){1'b0}}, ppn, {PAGE_SHIFT{1'b0}}};
    assign v_bit    = pte[PTE_V];
    assign r_bit    = pte[PTE_R];
    assign w_bit    = pte[PTE_W];
    assign x_bit    = pte[PTE_X];

    // Bits of the address taken from vaddr for a leaf at this level: the page
    // offset plus every VPN field below lvl. For a superpage the same span of
    // the PPN must be zero.
    assign sp_mask = (64'd1 << (PAGE_SHIFT + VPN_WIDTH * int'(lvl))) - 64'd1;

    assign next_base = ppn_addr;

    always_comb begin
        leaf  = 1'b0;
        fault = 1'b0;
        paddr = 64'd0;
        if (!v_bit || (!r_bit && w_bit)) begin
            fault = 1'b1;
        end else if (r_bit || x_bit) begin
            leaf = 1'b1;
            if ((lvl != '0) && ((ppn_addr & sp_mask) != 64'd0)) begin
                fault = 1'b1;
            end else begin
                paddr = (ppn_addr & ~sp_mask) | (vaddr & sp_mask);
            end
        end else if (lvl == '0) begin
            // pointer at the last level has nowhere to go
            fault = 1'b1;
        end
    end

    assign unused_bits = ^{pte[63:PPN_MSB+1], pte[PPN_LSB-1:PTE_X+1]};

endmodule

// File: rtl/sv_page_walker.sv
// ---------------------------------------------------------------------------
// sv_page_walker
// Sv39/Sv48 hardware page-table walker. Fetches one 64-byte line per level,
// picks the PTE beat out of the burst and resolves leaf/superpage/fault.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   walk_req/vaddr/ptbr         request (taken only while walk_ready)
//   walk_ready                  idle, can accept a request
//   walk_done                   one-cycle result pulse
//   walk_paddr/walk_fault       result, valid with walk_done
//   bus_reqcyc/reqack/req/reqtag  line read request handshake
//   bus_respcyc/respack/resp/resptag  response beat handshake
// ---------------------------------------------------------------------------
module sv_page_walker
    import riscv_mmu_pkg::*;
#(
    parameter int LEVELS         = 4,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int PTESIZE        = 8,
    parameter int LINE_BEATS     = 8,
    parameter int VPN_WIDTH      = 9,
    parameter int PAGE_SHIFT     = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      walk_req,
    input  logic [63:0]               walk_vaddr,
    input  logic [63:0]               walk_ptbr,
    output logic                      walk_ready,
    output logic                      walk_done,
    output logic [63:0]               walk_paddr,
    output logic                      walk_fault,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int PTE_SHIFT  = $clog2(PTESIZE);
    localparam int LINE_SHIFT = $clog2(PTESIZE * LINE_BEATS);
    localparam logic [LVL_W-1:0]  TOP_LVL   = LVL_W'(LEVELS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    walk_state_e       state;
    logic [63:0]       vaddr;
    logic [63:0]       pte_addr;
    logic [LVL_W-1:0]  lvl;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_idx;
    logic [63:0]       pte;

    logic              chk_leaf;
    logic              chk_fault;
    logic [63:0]       chk_next_base;
    logic [63:0]       chk_paddr;
    logic              unused_bits;

    // Byte address of the PTE for VPN field l of va inside table `base`.
    function automatic logic [63:0] pte_addr_f(input logic [63:0]      base,
                                               input logic [63:0]      va,
                                               input logic [LVL_W-1:0] l);
        logic [VPN_WIDTH-1:0] vpn;
        vpn = va[PAGE_SHIFT + VPN_WIDTH * int'(l) +: VPN_WIDTH];
        return base + (64'(vpn) << PTE_SHIFT);
    endfunction

    pte_check #(
        .LEVELS     (LEVELS),
        .VPN_WIDTH  (VPN_WIDTH),
        .PAGE_SHIFT (PAGE_SHIFT),
        .LVL_W      (LVL_W)
    ) u_pte_check (
        .pte       (pte),
        .lvl       (lvl),
        .vaddr     (vaddr),
        .leaf      (chk_leaf),
        .fault     (chk_fault),
        .next_base (chk_next_base),
        .paddr     (chk_paddr)
    );

    // The held PTE address supplies both the line request and the beat to keep.
    assign bus_req     = BUS_DATA_WIDTH'({pte_addr[63:LINE_SHIFT], {LINE_SHIFT{1'b0}}});
    assign beat_idx    = pte_addr[LINE_SHIFT-1:PTE_SHIFT];
    assign bus_reqtag  = BUS_TAG_WIDTH'(SYSBUS_RD_MEM_TAG);
    assign bus_respack = (state == ST_RESP) && bus_respcyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            walk_ready <= 1'b1;
            walk_done  <= 1'b0;
            walk_fault <= 1'b0;
            walk_paddr <= 64'd0;
            bus_reqcyc <= 1'b0;
            pte_addr   <= 64'd0;
            vaddr      <= 64'd0;
            lvl        <= '0;
            beat_cnt   <= '0;
            pte        <= 64'd0;
        end else begin
            walk_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (walk_req) begin
                        vaddr      <= walk_vaddr;
                        lvl        <= TOP_LVL;
                        pte_addr   <= pte_addr_f(walk_ptbr, walk_vaddr, TOP_LVL);
                        bus_reqcyc <= 1'b1;
                        walk_ready <= 1'b0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Whole line is always drained; only the addressed beat is kept.
                    if (bus_respcyc) begin
                        if (beat_cnt == beat_idx) begin
                            pte <= 64'(bus_resp);
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (chk_fault) begin
                        walk_fault <= 1'b1;
                        walk_paddr <= 64'd0;
                        walk_done  <= 1'b1;
                        state      <= ST_DONE;
                    end else if (chk_leaf) begin
                        walk_fault <= 1'b0;
                        walk_paddr <= chk_paddr;
                        walk_done  <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        lvl        <= lvl - 1'b1;
                        pte_addr   <= pte_addr_f(chk_next_base, vaddr, lvl - 1'b1);
                        bus_reqcyc <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    walk_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign unused_bits = ^{pte_addr[PTE_SHIFT-1:0], bus_resptag};

endmodule

// File: tb/tb_sv_page_walker.sv
module tb_sv_page_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic        walk_req;
    logic [63:0] walk_vaddr;
    logic [63:0] walk_ptbr;
    logic        walk_ready;
    logic        walk_done;
    logic [63:0] walk_paddr;
    logic        walk_fault;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    sv_page_walker dut (
        .clk         (clk),
        .reset       (reset),
        .walk_req    (walk_req),
        .walk_vaddr  (walk_vaddr),
        .walk_ptbr   (walk_ptbr),
        .walk_ready  (walk_ready),
        .walk_done   (walk_done),
        .walk_paddr  (walk_paddr),
        .walk_fault  (walk_fault),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]        pa;
        logic               f;
        logic signed [31:0] lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_req_q[$];
    logic [63:0] mem [logic [63:0]];

    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    req_cyc = 0;
    int    done_cnt = 0;
    int    req_cnt = 0;
    int    beats_acked = 0;
    int    ack_delay = 0;
    bit    gaps = 1'b0;
    string cur_name = "reset";

    localparam int R_IDLE = 0, R_HOLD = 1, R_ACK = 2, R_BEAT = 3;
    int          rs = R_IDLE;
    int          hold_cnt;
    int          beat;
    logic [63:0] line;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus_respcyc && bus_respack) beats_acked <= beats_acked + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s [%s]: got 0x%0h expected 0x%0h", name, cur_name, act, exp);
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'd0;
    endfunction

    // Result monitor: pops the scoreboard on every walk_done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (walk_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'(walk_done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("paddr", walk_paddr, e.pa);
                    check("fault", 64'(walk_fault), 64'(e.f));
                    if (e.lat >= 0) check("latency", 64'(cyc - req_cyc), 64'(e.lat));
                end
                done_cnt++;
            end
        end
    end

    // Bus memory model with optional request backpressure and response gaps
    initial begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = 64'd0;
        bus_resptag = 13'd0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                bus_reqack  = 1'b0;
                bus_respcyc = 1'b0;
                rs          = R_IDLE;
            end else begin
                case (rs)
                    R_IDLE: if (bus_reqcyc === 1'b1) begin
                        line = bus_req;
                        req_cnt++;
                        if (exp_req_q.size() == 0) begin
                            checks++;
                            $display("FAIL req_addr [%s]: got 0x%0h expected no request", cur_name, bus_req);
                        end else begin
                            check("req_addr", bus_req, exp_req_q.pop_front());
                        end
                        check("req_tag", 64'(bus_reqtag), 64'h1100);
                        if (ack_delay == 0) begin
                            bus_reqack = 1'b1;
                            rs = R_ACK;
                        end else begin
                            hold_cnt = ack_delay;
                            rs = R_HOLD;
                        end
                    end
                    R_HOLD: begin
                        check("reqcyc_held", 64'(bus_reqcyc), 64'd1);
                        check("req_stable", bus_req, line);
                        hold_cnt--;
                        if (hold_cnt == 0) begin
                            bus_reqack = 1'b1;
                            rs = R_ACK;
                        end
                    end
                    R_ACK: begin
                        bus_reqack = 1'b0;
                        check("reqcyc_drop", 64'(bus_reqcyc), 64'd0);
                        beat = 0;
                        bus_respcyc = 1'b1;
                        bus_resp = rd(line);
                        rs = R_BEAT;
                    end
                    default: begin
                        if (bus_respcyc) beat++;
                        if (beat == 8) begin
                            bus_respcyc = 1'b0;
                            rs = R_IDLE;
                        end else if (gaps && bus_respcyc) begin
                            bus_respcyc = 1'b0;
                        end else begin
                            bus_respcyc = 1'b1;
                            bus_resp = rd(line + 64'(8 * beat));
                        end
                    end
                endcase
            end
        end
    end

    task automatic push_reqs(input logic [63:0] a0, a1, a2, a3, input int n);
        if (n > 0) exp_req_q.push_back(a0);
        if (n > 1) exp_req_q.push_back(a1);
        if (n > 2) exp_req_q.push_back(a2);
        if (n > 3) exp_req_q.push_back(a3);
    endtask

    task automatic run_walk(input string name, input logic [63:0] va, ptbr, exp_pa,
                            input logic exp_f, input int exp_lat, input int exp_nreq,
                            input bit stray);
        int  r0;
        int  d0;
        bit  got;
        exp_t e;
        cur_name = name;
        e.pa = exp_pa; e.f = exp_f; e.lat = exp_lat;
        exp_q.push_back(e);
        @(negedge clk);
        check("ready_before", 64'(walk_ready), 64'd1);
        r0 = req_cnt;
        d0 = done_cnt;
        walk_vaddr = va;
        walk_ptbr  = ptbr;
        walk_req   = 1'b1;
        req_cyc    = cyc;
        @(negedge clk);
        walk_req = 1'b0;
        if (stray) begin
            @(negedge clk);
            walk_vaddr = 64'hFFFF_F000;
            walk_ptbr  = 64'h5000_0000;
            walk_req   = 1'b1;
            @(negedge clk);
            walk_req = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 64'(got), 64'd1);
        check("req_count", 64'(req_cnt - r0), 64'(exp_nreq));
        check("req_left", 64'(exp_req_q.size()), 64'd0);
        exp_req_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int b0;
        int r0;
        int d0;
        bit hit;
        reset      = 1'b1;
        walk_req   = 1'b0;
        walk_vaddr = 64'd0;
        walk_ptbr  = 64'd0;
        mem[64'h10000] = 64'h4401;
        mem[64'h11000] = 64'h4801;
        mem[64'h12010] = 64'h4C01;
        mem[64'h13018] = 64'h2000_00CF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready",   64'(walk_ready),  64'd1);
        check("rst_done",    64'(walk_done),   64'd0);
        check("rst_fault",   64'(walk_fault),  64'd0);
        check("rst_paddr",   walk_paddr,       64'd0);
        check("rst_reqcyc",  64'(bus_reqcyc),  64'd0);
        check("rst_req",     bus_req,          64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);

        // Sv48 four-level walk to a 4 KiB page
        push_reqs(64'h10000, 64'h11000, 64'h12000, 64'h13000, 4);
        run_walk("sv48_4k", 64'h403ABC, 64'h10000, 64'h8000_0ABC, 1'b0, 41, 4, 1'b0);

        // 2 MiB superpage at level 1
        mem[64'h12010] = 64'h2008_00CF;
        push_reqs(64'h10000, 64'h11000, 64'h12000, 0, 3);
        run_walk("superpage", 64'h403ABC, 64'h10000, 64'h8020_3ABC, 1'b0, 31, 3, 1'b0);

        // Same superpage with a nonzero low PPN field
        mem[64'h12010] = 64'h2008_04CF;
        push_reqs(64'h10000, 64'h11000, 64'h12000, 0, 3);
        run_walk("misaligned", 64'h403ABC, 64'h10000, 64'd0, 1'b1, 31, 3, 1'b0);

        // Invalid PTE at level 2: two full lines consumed
        mem[64'h12010] = 64'h4C01;
        mem[64'h11000] = 64'd0;
        b0 = beats_acked;
        push_reqs(64'h10000, 64'h11000, 0, 0, 2);
        run_walk("invalid", 64'h403ABC, 64'h10000, 64'd0, 1'b1, 21, 2, 1'b0);
        check("beats_acked", 64'(beats_acked - b0), 64'd16);

        // Backpressure on request and gapped response, plus a stray request
        mem[64'h11000] = 64'h4801;
        ack_delay = 5;
        gaps = 1'b1;
        push_reqs(64'h10000, 64'h11000, 64'h12000, 64'h13000, 4);
        run_walk("backpressure", 64'h403ABC, 64'h10000, 64'h8000_0ABC, 1'b0, -1, 4, 1'b1);
        ack_delay = 0;
        gaps = 1'b0;

        // Reset during the level-2 response burst
        cur_name = "reset_mid";
        push_reqs(64'h10000, 64'h11000, 0, 0, 2);
        @(negedge clk);
        r0 = req_cnt;
        d0 = done_cnt;
        walk_vaddr = 64'h403ABC;
        walk_ptbr  = 64'h10000;
        walk_req   = 1'b1;
        @(negedge clk);
        walk_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((req_cnt - r0) == 2 && rs == R_BEAT) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_lvl2_resp", 64'(hit), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready",  64'(walk_ready), 64'd1);
        check("abort_reqcyc", 64'(bus_reqcyc), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_req_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        push_reqs(64'h10000, 64'h11000, 64'h12000, 64'h13000, 4);
        run_walk("after_reset", 64'h403ABC, 64'h10000, 64'h8000_0ABC, 1'b0, 41, 4, 1'b0);

        cur_name = "end";
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
